// File: rtl/sump_cmd_decoder.sv
// sump_cmd_decoder
// ----------------
// Interprets 40-bit SUMP command words from the UART receiver.
// - Long commands (opcode bit 7 set) load the capture configuration registers.
// - Short commands pulse RUN/RESET strobes or start a byte-serial reply.
//
// Optional feature: define LOGIP_SUMP_METADATA_EN to enable the metadata
// reply on opcode 0x04. Without it, 0x04 is ignored like any unknown opcode.
//
// Ports:
//   clk_i        system clock (rising edge)
//   rst_i        synchronous active-high reset
//   cmd_i[39:0]  command word: [39:32] opcode, [31:0] parameter
//   stb_i        single-cycle strobe qualifying cmd_i
//   trig_mask_o  trigger mask          (0xC0)
//   trig_val_o   trigger values        (0xC1)
//   trig_cfg_o   trigger configuration (0xC2)
//   div_o        sample-rate divider   (0x80, param[23:0])
//   read_cnt_o   read count            (0x81, param[15:0])
//   delay_cnt_o  delay count           (0x81, param[31:16])
//   flags_o      flags                 (0x82, param[7:0])
//   arm_o        one-cycle pulse on RUN (0x01)
//   sw_rst_o     one-cycle pulse on RESET (0x00)
//   tx_data_o    reply byte
//   tx_valid_o   reply byte valid
//   tx_ready_i   transmitter ready (transfer when valid && ready)
module sump_cmd_decoder #(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [39:0] cmd_i,
  input  logic        stb_i,
  output logic [31:0] trig_mask_o,
  output logic [31:0] trig_val_o,
  output logic [31:0] trig_cfg_o,
  output logic [23:0] div_o,
  output logic [15:0] read_cnt_o,
  output logic [15:0] delay_cnt_o,
  output logic [7:0]  flags_o,
  output logic        arm_o,
  output logic        sw_rst_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i
);

  localparam logic [7:0] OP_RESET = 8'h00;
  localparam logic [7:0] OP_RUN   = 8'h01;
  localparam logic [7:0] OP_ID    = 8'h02;
  localparam logic [7:0] OP_MASK  = 8'hC0;
  localparam logic [7:0] OP_VAL   = 8'hC1;
  localparam logic [7:0] OP_CFG   = 8'hC2;
  localparam logic [7:0] OP_DIV   = 8'h80;
  localparam logic [7:0] OP_CNT   = 8'h81;
  localparam logic [7:0] OP_FLAGS = 8'h82;

  localparam logic [3:0] ID_LAST = 4'd3;

  typedef enum logic {IDLE, SEND} state_t;

  // "1ALS" device identifier, sent first byte first.
  function automatic logic [7:0] id_byte(input logic [3:0] i);
    case (i)
      4'd0:    id_byte = 8'h31;
      4'd1:    id_byte = 8'h41;
      4'd2:    id_byte = 8'h4C;
      4'd3:    id_byte = 8'h53;
      default: id_byte = 8'h00;
    endcase
  endfunction

`ifdef LOGIP_SUMP_METADATA_EN
  localparam logic [7:0]  OP_META   = 8'h04;
  localparam logic [3:0]  META_LAST = 4'd12;
  localparam logic [31:0] DEPTH_W   = 32'(DEPTH_WORDS);

  // Metadata: device name "logIP", then sample memory depth (MSB first), end.
  function automatic logic [7:0] meta_byte(input logic [3:0] i);
    case (i)
      4'd0:    meta_byte = 8'h01;
      4'd1:    meta_byte = 8'h6C;
      4'd2:    meta_byte = 8'h6F;
      4'd3:    meta_byte = 8'h67;
      4'd4:    meta_byte = 8'h49;
      4'd5:    meta_byte = 8'h50;
      4'd6:    meta_byte = 8'h00;
      4'd7:    meta_byte = 8'h21;
      4'd8:    meta_byte = DEPTH_W[31:24];
      4'd9:    meta_byte = DEPTH_W[23:16];
      4'd10:   meta_byte = DEPTH_W[15:8];
      4'd11:   meta_byte = DEPTH_W[7:0];
      default: meta_byte = 8'h00;
    endcase
  endfunction

  logic meta_q, meta_d;  // current reply is metadata rather than ID
`endif

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] trig_mask_q, trig_mask_d;
  logic [31:0] trig_val_q, trig_val_d;
  logic [31:0] trig_cfg_q, trig_cfg_d;
  logic [23:0] div_q, div_d;
  logic [15:0] read_cnt_q, read_cnt_d;
  logic [15:0] delay_cnt_q, delay_cnt_d;
  logic [7:0]  flags_q, flags_d;
  logic        arm_q, arm_d;
  logic        sw_rst_q, sw_rst_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;

  logic [7:0]  opcode;
  logic [31:0] param;
  logic [3:0]  last_idx;
  logic [3:0]  idx_inc;
  logic [7:0]  next_byte;

  assign opcode = cmd_i[39:32];
  assign param  = cmd_i[31:0];
  assign idx_inc = idx_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    trig_mask_d = trig_mask_q;
    trig_val_d  = trig_val_q;
    trig_cfg_d  = trig_cfg_q;
    div_d       = div_q;
    read_cnt_d  = read_cnt_q;
    delay_cnt_d = delay_cnt_q;
    flags_d     = flags_q;
    arm_d       = 1'b0;
    sw_rst_d    = 1'b0;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    last_idx    = ID_LAST;
    next_byte   = id_byte(idx_inc);
`ifdef LOGIP_SUMP_METADATA_EN
    meta_d = meta_q;
    if (meta_q) begin
      last_idx  = META_LAST;
      next_byte = meta_byte(idx_inc);
    end
`endif

    // Reply progress: advance only on an accepted byte so data stays stable
    // under backpressure.
    if (state_q == SEND && tx_ready_i) begin
      if (idx_q == last_idx) begin
        state_d    = IDLE;
        idx_d      = 4'd0;
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
      end else begin
        idx_d     = idx_inc;
        tx_data_d = next_byte;
      end
    end

    // Command decode. Reply-start opcodes are only honoured from IDLE (based
    // on the current state, so a strobe coinciding with the final transfer is
    // still ignored). RESET is evaluated last so it overrides any transfer.
    if (stb_i) begin
      case (opcode)
        OP_MASK:  trig_mask_d = param;
        OP_VAL:   trig_val_d  = param;
        OP_CFG:   trig_cfg_d  = param;
        OP_DIV:   div_d       = param[23:0];
        OP_CNT: begin
          read_cnt_d  = param[15:0];
          delay_cnt_d = param[31:16];
        end
        OP_FLAGS: flags_d = param[7:0];
        OP_RUN:   arm_d   = 1'b1;
        OP_ID: begin
          if (state_q == IDLE) begin
            state_d    = SEND;
            idx_d      = 4'd0;
            tx_valid_d = 1'b1;
            tx_data_d  = id_byte(4'd0);
`ifdef LOGIP_SUMP_METADATA_EN
            meta_d = 1'b0;
`endif
          end
        end
`ifdef LOGIP_SUMP_METADATA_EN
        OP_META: begin
          if (state_q == IDLE) begin
            state_d    = SEND;
            idx_d      = 4'd0;
            tx_valid_d = 1'b1;
            tx_data_d  = meta_byte(4'd0);
            meta_d     = 1'b1;
          end
        end
`endif
        OP_RESET: begin
          sw_rst_d   = 1'b1;
          state_d    = IDLE;
          idx_d      = 4'd0;
          tx_valid_d = 1'b0;
          tx_data_d  = 8'h00;
        end
        default: ;  // unknown opcodes (incl. XON/XOFF) have no effect
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      trig_mask_q <= '0;
      trig_val_q  <= '0;
      trig_cfg_q  <= '0;
      div_q       <= '0;
      read_cnt_q  <= '0;
      delay_cnt_q <= '0;
      flags_q     <= '0;
      arm_q       <= 1'b0;
      sw_rst_q    <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
`ifdef LOGIP_SUMP_METADATA_EN
      meta_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      trig_mask_q <= trig_mask_d;
      trig_val_q  <= trig_val_d;
      trig_cfg_q  <= trig_cfg_d;
      div_q       <= div_d;
      read_cnt_q  <= read_cnt_d;
      delay_cnt_q <= delay_cnt_d;
      flags_q     <= flags_d;
      arm_q       <= arm_d;
      sw_rst_q    <= sw_rst_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
`ifdef LOGIP_SUMP_METADATA_EN
      meta_q      <= meta_d;
`endif
    end
  end

  assign trig_mask_o = trig_mask_q;
  assign trig_val_o  = trig_val_q;
  assign trig_cfg_o  = trig_cfg_q;
  assign div_o       = div_q;
  assign read_cnt_o  = read_cnt_q;
  assign delay_cnt_o = delay_cnt_q;
  assign flags_o     = flags_q;
  assign arm_o       = arm_q;
  assign sw_rst_o    = sw_rst_q;
  assign tx_data_o   = tx_data_q;
  assign tx_valid_o  = tx_valid_q;

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Testbench for sump_cmd_decoder: directed test-plan sequences followed by
// randomized command/backpressure traffic, all checked every cycle against a
// transaction-level model (register shadow copies plus a queue of pending
// reply bytes). Define LOGIP_SUMP_METADATA_EN to also cover opcode 0x04.
module tb_sump_cmd_decoder;

  localparam int DEPTH = 4096;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [39:0] cmd_i;
  logic        stb_i;
  logic [31:0] trig_mask_o, trig_val_o, trig_cfg_o;
  logic [23:0] div_o;
  logic [15:0] read_cnt_o, delay_cnt_o;
  logic [7:0]  flags_o;
  logic        arm_o, sw_rst_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;

  always #5 clk_i = ~clk_i;

  sump_cmd_decoder #(.DEPTH_WORDS(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_i       (cmd_i),
    .stb_i       (stb_i),
    .trig_mask_o (trig_mask_o),
    .trig_val_o  (trig_val_o),
    .trig_cfg_o  (trig_cfg_o),
    .div_o       (div_o),
    .read_cnt_o  (read_cnt_o),
    .delay_cnt_o (delay_cnt_o),
    .flags_o     (flags_o),
    .arm_o       (arm_o),
    .sw_rst_o    (sw_rst_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i)
  );

  int n_vectors = 0;
  int n_miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mask, m_val, m_cfg;
  logic [23:0] m_div;
  logic [15:0] m_read, m_delay;
  logic [7:0]  m_flags;
  logic        m_arm, m_sw;
  logic [7:0]  m_reply[$];   // bytes still to be sent; front = byte on the bus

  task automatic model_clear();
    m_mask = 0; m_val = 0; m_cfg = 0; m_div = 0; m_read = 0; m_delay = 0;
    m_flags = 0; m_arm = 0; m_sw = 0;
    m_reply.delete();
  endtask

  task automatic model_step(input logic r, input logic s, input logic [39:0] c, input logic rdy);
    bit busy;
    logic [7:0]  op;
    logic [31:0] p;
    if (r) begin
      model_clear();
      return;
    end
    busy = (m_reply.size() != 0);
    if (busy && rdy) void'(m_reply.pop_front());
    m_arm = 0;
    m_sw  = 0;
    op = c[39:32];
    p  = c[31:0];
    if (s) begin
      case (op)
        8'hC0: m_mask = p;
        8'hC1: m_val  = p;
        8'hC2: m_cfg  = p;
        8'h80: m_div  = p[23:0];
        8'h81: begin m_read = p[15:0]; m_delay = p[31:16]; end
        8'h82: m_flags = p[7:0];
        8'h01: m_arm = 1;
        8'h00: begin m_sw = 1; m_reply.delete(); end
        8'h02: if (!busy) m_reply = '{8'h31, 8'h41, 8'h4C, 8'h53};
`ifdef LOGIP_SUMP_METADATA_EN
        8'h04: if (!busy) begin
          logic [31:0] d;
          d = DEPTH;
          m_reply = '{8'h01, 8'h6C, 8'h6F, 8'h67, 8'h49, 8'h50, 8'h00,
                      8'h21, d[31:24], d[23:16], d[15:8], d[7:0], 8'h00};
        end
`endif
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    chk("trig_mask", trig_mask_o, m_mask);
    chk("trig_val", trig_val_o, m_val);
    chk("trig_cfg", trig_cfg_o, m_cfg);
    chk("div", {8'h0, div_o}, {8'h0, m_div});
    chk("read_cnt", {16'h0, read_cnt_o}, {16'h0, m_read});
    chk("delay_cnt", {16'h0, delay_cnt_o}, {16'h0, m_delay});
    chk("flags", {24'h0, flags_o}, {24'h0, m_flags});
    chk("arm", {31'h0, arm_o}, {31'h0, m_arm});
    chk("sw_rst", {31'h0, sw_rst_o}, {31'h0, m_sw});
    chk("tx_valid", {31'h0, tx_valid_o}, {31'h0, (m_reply.size() != 0)});
    if (m_reply.size() != 0) chk("tx_data", {24'h0, tx_data_o}, {24'h0, m_reply[0]});
  endtask

  // Apply one cycle of inputs, advance model at the edge, check #1 later.
  task automatic step(input logic r, input logic s, input logic [39:0] c, input logic rdy);
    rst_i = r; stb_i = s; cmd_i = c; tx_ready_i = rdy;
    @(posedge clk_i);
    model_step(r, s, c, rdy);
    #1;
    if (s) $display("cmd op=%h param=%h rst=%0b ready=%0b -> valid=%0b data=%h",
                    c[39:32], c[31:0], r, rdy, tx_valid_o, tx_data_o);
    check_all();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(0, 0, 40'h0, rdy);
  endtask

  logic [7:0] ops [14] = '{8'hC0, 8'hC1, 8'hC2, 8'h80, 8'h81, 8'h82, 8'h01,
                           8'h00, 8'h02, 8'h02, 8'h04, 8'h11, 8'h13, 8'h55};

  initial begin
    rst_i = 1; stb_i = 0; cmd_i = '0; tx_ready_i = 0;
    model_clear();

    // Reset for two cycles, with a command that must be lost.
    step(1, 1, {8'hC0, 32'hFFFF_FFFF}, 1);
    step(1, 0, 40'h0, 1);
    chk("rst_tx_data", {24'h0, tx_data_o}, 32'h0);
    idle(1, 1);

    // Register loads.
    step(0, 1, {8'hC0, 32'hDEAD_BEEF}, 1);
    step(0, 1, {8'h80, 32'h1234_5678}, 1);
    step(0, 1, {8'h81, 32'hABCD_1234}, 1);
    step(0, 1, {8'hC1, 32'h0BAD_F00D}, 1);
    step(0, 1, {8'hC2, 32'h0000_0F0F}, 1);
    step(0, 1, {8'h82, 32'hFFFF_FF5A}, 1);
    idle(1, 1);

    // ID with toggling backpressure.
    step(0, 1, {8'h02, 32'h0}, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 40'h0, (i % 2) == 0);
    idle(2, 1);

    // Abort a stalled ID reply.
    step(0, 1, {8'h02, 32'h0}, 0);
    idle(3, 0);
    step(0, 1, {8'h00, 32'h0}, 0);
    idle(3, 1);

    // Pulses and ignored opcodes.
    step(0, 1, {8'h01, 32'h0}, 1);
    idle(2, 1);
    step(0, 1, {8'h11, 32'hFFFF_FFFF}, 1);
    step(0, 1, {8'h55, 32'h1111_1111}, 1);
    step(0, 1, {8'h04, 32'h0}, 1);
    idle(2, 1);

    // ID during SEND does not restart; ID coinciding with last transfer ignored.
    step(0, 1, {8'h02, 32'h0}, 1);
    step(0, 1, {8'h02, 32'h0}, 1);
    step(0, 0, 40'h0, 1);
    step(0, 1, {8'h02, 32'h0}, 1);
    step(0, 1, {8'h02, 32'h0}, 1);
    idle(3, 1);

`ifdef LOGIP_SUMP_METADATA_EN
    step(0, 1, {8'h04, 32'h0}, 1);
    idle(15, 1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      logic r, s, rdy;
      logic [39:0] c;
      r   = ($urandom_range(0, 299) == 0);
      s   = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      c[31:0]  = $urandom;
      c[39:32] = ($urandom_range(0, 9) == 0) ? 8'($urandom)
                                             : ops[$urandom_range(0, 13)];
      step(r, s, c, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/sump_cmd_decoder.md
# sump_cmd_decoder

Consumes 40-bit command words strobed out of the UART receiver and interprets them as SUMP logic-analyzer commands. Long commands (opcode bit 7 set) load the capture configuration registers. Short commands pulse control strobes or start a byte-serial reply (device ID) toward the UART transmitter over a valid/ready handshake. The block sits between `uart_rx` and the trigger/sampler/`uart_tx` stages.

## Interface
- `DEPTH_WORDS`, default 4096: sample memory depth reported in metadata.
- `clk_i`  in  1: system clock; all logic samples on the rising edge.
- `rst_i`  in  1: reset, synchronous, active-high.
- `cmd_i`  in  40: command word.
  - `[39:32]` is the opcode.
  - `[31:0]` is the parameter; the first parameter byte received sits in `[7:0]`.
- `stb_i`  in  1: single-cycle strobe; `cmd_i` is valid in the same cycle.
- `trig_mask_o`  out  32: trigger mask (opcode 0xC0).
- `trig_val_o`  out  32: trigger values (opcode 0xC1).
- `trig_cfg_o`  out  32: trigger configuration (opcode 0xC2).
- `div_o`  out  24: sample-rate divider, loaded from `cmd_i[23:0]` (opcode 0x80).
- `read_cnt_o`  out  16: read count, loaded from `cmd_i[15:0]` (opcode 0x81).
- `delay_cnt_o`  out  16: delay count, loaded from `cmd_i[31:16]` (opcode 0x81).
- `flags_o`  out  8: flags, loaded from `cmd_i[7:0]` (opcode 0x82).
- `arm_o`  out  1: one-cycle pulse on RUN (0x01).
- `sw_rst_o`  out  1: one-cycle pulse on RESET (0x00).
- `tx_data_o`  out  8: reply byte.
- `tx_valid_o`  out  1: reply byte valid.
- `tx_ready_i`  in  1: transmitter ready; a transfer occurs on a cycle where both `tx_valid_o` and `tx_ready_i` are high.

## Operation
- Reset values: every register output 0; `arm_o`, `sw_rst_o`, `tx_valid_o` 0; `tx_data_o` 0; FSM in IDLE.
- Decode happens on `stb_i`.
- Unknown opcodes are ignored with no side effect. This includes XON (0x11) and XOFF (0x13).
- Parameter bits beyond a register's width are discarded.
- Short command parameter bits are don't-care.
- FSM states:
  - IDLE, then SEND on ID (0x02): loads a byte index of 0.
  - SEND: `tx_valid_o`=1 with `tx_data_o`=ROM[index]. On each transfer the index increments. After the transfer of the last byte the FSM returns to IDLE.
- ID reply is exactly 4 bytes in order: 0x31, 0x41, 0x4C, 0x53 ("1ALS").
- `tx_data_o` and `tx_valid_o` remain stable while `tx_ready_i`=0. Valid never drops without a transfer, except on reset or a RESET command.
- Commands arriving during SEND:
  - Register loads and RUN take effect normally.
  - ID (and metadata when enabled) is ignored; there is no queueing and no restart.
  - RESET (0x00) pulses `sw_rst_o` and aborts SEND. `tx_valid_o`=0 from the next cycle, and the FSM returns to IDLE. Configuration registers keep their values.
- `rst_i` has priority over `stb_i` in the same cycle: the command is lost and all outputs take their reset values.

## Timing
- Register load: the new value is visible on the output in the cycle after `stb_i` (1-cycle latency).
- `arm_o` / `sw_rst_o`: high for exactly the one cycle after `stb_i`.
- Back-to-back strobes on consecutive cycles are each decoded; there is no minimum gap.
- Reply:
  - `tx_valid_o` rises in the cycle after the ID strobe.
  - With `tx_ready_i` held high, one byte transfers per cycle, so the ID reply takes 4 cycles.
  - `tx_valid_o` is 0 in the cycle after the last transfer.
- A transfer on the last byte and a new ID strobe in the same cycle: the strobe is ignored, because the FSM was in SEND.

## Configuration
- Macro `LOGIP_SUMP_METADATA_EN`.
- Defined: opcode 0x04 starts SEND with the metadata ROM, 13 bytes in order:
  - 0x01 followed by "logIP" (0x6C, 0x6F, 0x67, 0x49, 0x50) and 0x00;
  - 0x21 followed by `DEPTH_WORDS` as 32 bits, MSB first;
  - 0x00.
- Metadata follows the same handshake, abort and ignore rules as ID.
- Undefined: 0x04 is an unknown opcode and is ignored, and no metadata ROM is synthesized.

## Test plan
- Reset: `rst_i`=1 for 2 cycles, then release -> all outputs 0 and `tx_valid_o`=0.
- Register loads:
  - Strobe 0xC0_DEADBEEF -> `trig_mask_o`=0xDEADBEEF the next cycle.
  - Strobe 0x80_12345678 -> `div_o`=0x345678.
  - Strobe 0x81_ABCD1234 -> `read_cnt_o`=0x1234 and `delay_cnt_o`=0xABCD.
- ID with backpressure:
  - Strobe 0x02_00000000 with `tx_ready_i` toggling 1,0,1,0,... -> bytes 0x31, 0x41, 0x4C, 0x53 each transferred once.
  - Data is held stable through the not-ready cycles, and `tx_valid_o` is 0 after the 4th transfer.
- Abort: strobe ID, hold `tx_ready_i`=0 for 3 cycles, then strobe 0x00 -> `sw_rst_o` pulses once, `tx_valid_o`=0 the next cycle, and `trig_val_o` keeps its previously loaded value.
- Pulses and ignored opcodes:
  - Strobe 0x01 -> `arm_o` high for exactly 1 cycle.
  - Strobe 0x11 or 0x55 -> no output changes.
  - Strobe 0x02 during SEND -> the reply is not restarted.
- Metadata (`LOGIP_SUMP_METADATA_EN` defined, `DEPTH_WORDS`=4096): strobe 0x04 with `tx_ready_i`=1 -> 13 bytes, ending with 0x21, 0x00, 0x00, 0x10, 0x00, 0x00.
